// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the EXE-stage forwarding/hazard controller.
// Select encoding for the three EXE operand muxes lives here.
package exe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_SEL_REG = 2'd0,
    FWD_SEL_MEM = 2'd1,
    FWD_SEL_WB  = 2'd2
  } fwd_sel_e;

  // Operand positions used to index the per-source match vectors.
  localparam int NUM_SRC = 3;
  localparam int SRC_1   = 0;
  localparam int SRC_2   = 1;
  localparam int SRC_ST  = 2;

  // MEM holds the younger producer, so it wins over WB.
  function automatic fwd_sel_e pick_sel(input logic mem_hit, input logic wb_hit,
                                        input logic en);
    fwd_sel_e sel;
    sel = FWD_SEL_REG;
    if (en && mem_hit)     sel = FWD_SEL_MEM;
    else if (en && wb_hit) sel = FWD_SEL_WB;
    return sel;
  endfunction

endpackage

// File: rtl/exe_hazard_ctrl_if.sv
// Bundle of decoded ID fields, control inputs and mux-select/stall outputs
// for the EXE hazard controller.
interface exe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  // No valid/ready pair here: id_valid qualifies the ID fields for the current
  // cycle only, and while hazard_stall=1 the producer must hold them unchanged.
  logic             fwd_en;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_is_store;
  logic [REG_W-1:0] id_st_src;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic [1:0]       val1_sel;
  logic [1:0]       val2_sel;
  logic [1:0]       st_val_sel;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output fwd_en, flush, id_valid, id_src1, id_src2, id_two_src, id_is_store,
           id_st_src, id_dest, id_wb_en, id_mem_r_en,
    input  val1_sel, val2_sel, st_val_sel, hazard_stall, stall_cnt
  );

  modport slave (
    input  fwd_en, flush, id_valid, id_src1, id_src2, id_two_src, id_is_store,
           id_st_src, id_dest, id_wb_en, id_mem_r_en,
    output val1_sel, val2_sel, st_val_sel, hazard_stall, stall_cnt
  );
endinterface

// File: rtl/exe_hazard_ctrl_match.sv
// Single source-vs-slot dependency check; register 0 never matches.
module hazard_match
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             valid_i,
  input  logic             wb_en_i,
  input  logic [REG_W-1:0] dest_i,
  output logic             hit_o
);
  assign hit_o = valid_i && wb_en_i && (dest_i == src_i) && (src_i != '0);
endmodule

// File: rtl/exe_hazard_ctrl.sv
// Tracks EX/MEM/WB destination info, drives EXE forwarding selects and the
// load-use / RAW stall that freezes IF/ID and bubbles EX.
module exe_hazard_ctrl
  import exe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  exe_hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
  } slot_t;

  typedef struct packed {
    slot_t            slot;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
    logic             is_store;
    logic [REG_W-1:0] st_src;
  } ex_slot_t;

  ex_slot_t         ex_q, ex_d;
  slot_t            mem_q, wb_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0][REG_W-1:0] ex_src, id_src;
  logic [NUM_SRC-1:0]            ex_mem_hit, ex_wb_hit;
  logic [NUM_SRC-1:0]            id_ex_hit, id_mem_hit;
  logic [NUM_SRC-1:0]            id_use;
  logic                          raw, stall, sel_en;
  fwd_sel_e                      val1_sel, val2_sel, st_val_sel;
  logic                          unused_bits;

  assign ex_src[SRC_1]  = ex_q.src1;
  assign ex_src[SRC_2]  = ex_q.src2;
  assign ex_src[SRC_ST] = ex_q.st_src;
  assign id_src[SRC_1]  = bus.id_src1;
  assign id_src[SRC_2]  = bus.id_src2;
  assign id_src[SRC_ST] = bus.id_st_src;

  // EX consumer against older producers (forwarding) and ID consumer against
  // EX/MEM producers (stalling).
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    hazard_match #(.REG_W(REG_W)) u_ex_mem (
      .src_i(ex_src[i]), .valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en),
      .dest_i(mem_q.dest), .hit_o(ex_mem_hit[i]));
    hazard_match #(.REG_W(REG_W)) u_ex_wb (
      .src_i(ex_src[i]), .valid_i(wb_q.valid), .wb_en_i(wb_q.wb_en),
      .dest_i(wb_q.dest), .hit_o(ex_wb_hit[i]));
    hazard_match #(.REG_W(REG_W)) u_id_ex (
      .src_i(id_src[i]), .valid_i(ex_q.slot.valid), .wb_en_i(ex_q.slot.wb_en),
      .dest_i(ex_q.slot.dest), .hit_o(id_ex_hit[i]));
    hazard_match #(.REG_W(REG_W)) u_id_mem (
      .src_i(id_src[i]), .valid_i(mem_q.valid), .wb_en_i(mem_q.wb_en),
      .dest_i(mem_q.dest), .hit_o(id_mem_hit[i]));
  end

  assign sel_en = ex_q.slot.valid && bus.fwd_en;

  always_comb begin
    val1_sel   = pick_sel(ex_mem_hit[SRC_1], ex_wb_hit[SRC_1], sel_en);
    val2_sel   = pick_sel(ex_mem_hit[SRC_2], ex_wb_hit[SRC_2], sel_en && ex_q.two_src);
    st_val_sel = pick_sel(ex_mem_hit[SRC_ST], ex_wb_hit[SRC_ST], sel_en && ex_q.is_store);
  end

  assign id_use = {bus.id_is_store, bus.id_two_src, 1'b1};

  // Without forwarding the write-before-read register file covers WB only.
  always_comb begin
    raw = 1'b0;
    if (bus.fwd_en) raw = ex_q.slot.mem_r_en && |(id_use & id_ex_hit);
    else            raw = |(id_use & (id_ex_hit | id_mem_hit));
  end

  assign stall = bus.id_valid && raw && !bus.flush;

  always_comb begin
    ex_d = '0;
    if (bus.id_valid && !stall && !bus.flush) begin
      ex_d.slot.valid    = 1'b1;
      ex_d.slot.dest     = bus.id_dest;
      ex_d.slot.wb_en    = bus.id_wb_en;
      ex_d.slot.mem_r_en = bus.id_mem_r_en;
      ex_d.src1          = bus.id_src1;
      ex_d.src2          = bus.id_src2;
      ex_d.two_src       = bus.id_two_src;
      ex_d.is_store      = bus.id_is_store;
      ex_d.st_src        = bus.id_st_src;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q.slot;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Load flags are only consulted in EX; later copies are kept for visibility.
  assign unused_bits = mem_q.mem_r_en ^ wb_q.mem_r_en;

  assign bus.val1_sel     = val1_sel;
  assign bus.val2_sel     = val2_sel;
  assign bus.st_val_sel   = st_val_sel;
  assign bus.hazard_stall = stall;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl: forwarding selects, stalls, flush, reset.
module tb_exe_hazard_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  exe_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();

  exe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // v, src1, src2, two_src, is_store, st_src, dest, wb_en, mem_r_en
  task automatic drive(input int v, input int s1, input int s2, input int two,
                       input int st, input int sts, input int d, input int wb,
                       input int ld);
    bus.id_valid    = 1'(v);
    bus.id_src1     = 5'(s1);
    bus.id_src2     = 5'(s2);
    bus.id_two_src  = 1'(two);
    bus.id_is_store = 1'(st);
    bus.id_st_src   = 5'(sts);
    bus.id_dest     = 5'(d);
    bus.id_wb_en    = 1'(wb);
    bus.id_mem_r_en = 1'(ld);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  task automatic check_sels(input string tag, input int v1, input int v2, input int sv);
    check({tag, ".val1"}, 32'(bus.val1_sel), 32'(v1));
    check({tag, ".val2"}, 32'(bus.val2_sel), 32'(v2));
    check({tag, ".st"},   32'(bus.st_val_sel), 32'(sv));
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    bus.fwd_en = 1'b1;
    bus.flush  = 1'b0;
    idle();
    step();
    step();
    check_sels("reset", 0, 0, 0);
    check("reset.stall", 32'(bus.hazard_stall), 0);
    check("reset.cnt", bus.stall_cnt, 0);
    rst = 1'b0;

    // add r3,r1,r2 ; sub r4,r3,r5 ; or r10,r3,r0
    drive(1, 1, 2, 1, 0, 0, 3, 1, 0);
    step();
    drive(1, 3, 5, 1, 0, 0, 4, 1, 0);
    check("b2b.stall", 32'(bus.hazard_stall), 0);
    step();
    drive(1, 3, 0, 1, 0, 0, 10, 1, 0);
    check_sels("b2b.mem", 1, 0, 0);
    step();
    idle();
    check_sels("b2b.wb", 2, 0, 0);
    drain();

    // lw r2,0(r9) ; add r6,r2,r2
    drive(1, 9, 0, 0, 0, 0, 2, 1, 1);
    step();
    drive(1, 2, 2, 1, 0, 0, 6, 1, 0);
    check("lu.stall1", 32'(bus.hazard_stall), 1);
    check("lu.cnt0", bus.stall_cnt, 0);
    step();
    check("lu.stall2", 32'(bus.hazard_stall), 0);
    check("lu.cnt1", bus.stall_cnt, 1);
    step();
    idle();
    check_sels("lu.fwd", 2, 2, 0);
    drain();

    // Two writers of r7 in MEM and WB; consumer must take MEM.
    drive(1, 1, 0, 0, 0, 0, 7, 1, 0);
    step();
    drive(1, 2, 0, 0, 0, 0, 7, 1, 0);
    step();
    drive(1, 7, 7, 1, 0, 0, 11, 1, 0);
    check("dbl.stall", 32'(bus.hazard_stall), 0);
    step();
    idle();
    check_sels("dbl", 1, 1, 0);
    drain();

    // add r8 ; sw r8,0(r9)
    drive(1, 1, 2, 1, 0, 0, 8, 1, 0);
    step();
    drive(1, 9, 0, 0, 1, 8, 0, 0, 0);
    step();
    idle();
    check_sels("st", 0, 0, 1);
    drain();
    drive(1, 1, 2, 1, 0, 0, 8, 1, 0);
    step();
    drive(1, 9, 8, 0, 1, 8, 0, 0, 0);
    step();
    idle();
    check_sels("st_imm", 0, 0, 1);
    drain();

    // Register 0: neither an ALU write nor a load to r0 creates a dependency.
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0);
    step();
    drive(1, 0, 0, 1, 1, 0, 12, 1, 0);
    check("r0.stall", 32'(bus.hazard_stall), 0);
    step();
    idle();
    check_sels("r0", 0, 0, 0);
    drain();
    drive(1, 1, 0, 0, 0, 0, 0, 1, 1);
    step();
    drive(1, 0, 0, 1, 0, 0, 12, 1, 0);
    check("r0ld.stall", 32'(bus.hazard_stall), 0);
    drain();

    // fwd_en=0: RAW on an ALU result stalls two cycles, then no forwarding.
    bus.fwd_en = 1'b0;
    drive(1, 1, 2, 1, 0, 0, 3, 1, 0);
    step();
    drive(1, 3, 1, 1, 0, 0, 13, 1, 0);
    check("nf.stall1", 32'(bus.hazard_stall), 1);
    step();
    check("nf.stall2", 32'(bus.hazard_stall), 1);
    step();
    check("nf.stall3", 32'(bus.hazard_stall), 0);
    step();
    idle();
    check_sels("nf", 0, 0, 0);
    check("nf.cnt", bus.stall_cnt, 3);
    bus.fwd_en = 1'b1;
    drain();

    // fwd_en drop takes effect combinationally on a live MEM forward.
    drive(1, 1, 2, 1, 0, 0, 3, 1, 0);
    step();
    drive(1, 3, 0, 0, 0, 0, 14, 1, 0);
    step();
    idle();
    check("tog.on", 32'(bus.val1_sel), 1);
    bus.fwd_en = 1'b0;
    #1;
    check("tog.off", 32'(bus.val1_sel), 0);
    bus.fwd_en = 1'b1;
    drain();

    // Flush during a load-use stall: no stall, killed add never reaches EX.
    drive(1, 9, 0, 0, 0, 0, 2, 1, 1);
    step();
    bus.flush = 1'b1;
    drive(1, 2, 0, 0, 0, 0, 6, 1, 0);
    check("fl.stall", 32'(bus.hazard_stall), 0);
    step();
    bus.flush = 1'b0;
    drive(1, 6, 0, 0, 0, 0, 15, 1, 0);
    check("fl.stall2", 32'(bus.hazard_stall), 0);
    step();
    idle();
    check("fl.bubble", 32'(bus.val1_sel), 0);
    check("fl.cnt", bus.stall_cnt, 3);
    drain();

    // Reset mid-stream drops all tracking.
    drive(1, 1, 2, 1, 0, 0, 3, 1, 0);
    step();
    drive(1, 3, 0, 0, 0, 0, 16, 1, 0);
    step();
    idle();
    check("rst.pre", 32'(bus.val1_sel), 1);
    rst = 1'b1;
    step();
    check_sels("rst.mid", 0, 0, 0);
    check("rst.stall", 32'(bus.hazard_stall), 0);
    check("rst.cnt", bus.stall_cnt, 0);
    rst = 1'b0;
    step();
    check_sels("rst.post", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
